// File: rtl/demux_16bit_1i_6o_reg_pkg.sv
// Shared select encodings and destination count for the six-way write-back demux.
package demux_16bit_1i_6o_reg_pkg;

    localparam int NUM_DEST = 6;

    typedef enum logic [2:0] {
        SEL_A = 3'd0,
        SEL_B = 3'd1,
        SEL_C = 3'd2,
        SEL_D = 3'd3,
        SEL_E = 3'd4,
        SEL_F = 3'd5
    } sel_e;

    function automatic logic sel_legal(input logic [2:0] sel);
        return sel <= 3'(SEL_F);
    endfunction

endpackage

// File: rtl/demux_16bit_1i_6o_reg_fifo_2entry.sv
// Two-entry request FIFO; the head is always visible on dout while not empty.
module fifo_2entry #(
    parameter int W = 19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         w_push_ok;
    logic         w_pop_ok;

    assign full      = (r_count == 2'd2);
    assign empty     = (r_count == 2'd0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_push_ok = push && !full;
    assign w_pop_ok  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push_ok) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop_ok)  r_rd_ptr <= ~r_rd_ptr;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= din;
    end

endmodule

// File: rtl/demux_16bit_1i_6o_reg.sv
// Write-back demux: buffers {select,data} requests and drains them into six holding registers.
module demux_16bit_1i_6o_reg
    import demux_16bit_1i_6o_reg_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       s,
    input  logic [WIDTH-1:0] din,
    input  logic             stall,
    input  logic             err_clr,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] e,
    output logic [WIDTH-1:0] f,
    output logic [5:0]       ld,
    output logic             err,
    output logic [15:0]      wr_cnt
);

    logic [WIDTH+2:0] w_head;
    logic [2:0]       w_head_sel;
    logic [WIDTH-1:0] w_head_data;
    logic [1:0]       w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic             w_legal;
    logic [5:0]       w_ld_next;

    logic [WIDTH-1:0] r_dest [NUM_DEST];
    logic [5:0]       r_ld;
    logic             r_err;
    logic [15:0]      r_wr_cnt;

    // Readiness looks at the registered count only, so a same-edge pop never frees a slot.
    assign in_ready    = !rst && (w_count < 2'(DEPTH));
    assign w_push      = in_valid && in_ready;
    assign w_pop       = !stall && !w_empty;
    assign w_head_sel  = w_head[WIDTH+2:WIDTH];
    assign w_head_data = w_head[WIDTH-1:0];
    assign w_legal     = sel_legal(w_head_sel);

    fifo_2entry #(
        .W(WIDTH + 3)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (w_push),
        .pop  (w_pop),
        .din  ({s, din}),
        .dout (w_head),
        .count(w_count),
        .full (w_full),
        .empty(w_empty)
    );

    always_comb begin
        w_ld_next = 6'b0;
        if (w_pop && w_legal) w_ld_next[w_head_sel] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DEST; i++) r_dest[i] <= '0;
            r_ld     <= 6'b0;
            r_err    <= 1'b0;
            r_wr_cnt <= 16'd0;
        end else begin
            r_ld <= w_ld_next;
            for (int i = 0; i < NUM_DEST; i++) begin
                if (w_ld_next[i]) r_dest[i] <= w_head_data;
            end
            if (w_pop && w_legal) r_wr_cnt <= r_wr_cnt + 16'd1;
            // An illegal drain outranks a clear arriving on the same edge.
            if (w_pop && !w_legal) r_err <= 1'b1;
            else if (err_clr)      r_err <= 1'b0;
        end
    end

    assign a      = r_dest[SEL_A];
    assign b      = r_dest[SEL_B];
    assign c      = r_dest[SEL_C];
    assign d      = r_dest[SEL_D];
    assign e      = r_dest[SEL_E];
    assign f      = r_dest[SEL_F];
    assign ld     = r_ld;
    assign err    = r_err;
    assign wr_cnt = r_wr_cnt;

endmodule

// File: doc/demux_16bit_1i_6o_reg.md
Name: demux_16bit_1i_6o_reg

Overview:
Write-side counterpart of the six-way 16-bit read mux. It accepts one 16-bit result plus a 3-bit destination select, and delivers the value into one of six holding registers (a..f) that feed the datapath. A 2-entry input FIFO, a valid/ready handshake and a downstream stall input let the accumulator core issue write-backs while the destination bank is busy.

Parameters:
WIDTH, 16, data width of input and of each destination register
DEPTH, 2, input FIFO entries (fixed at 2; other values unsupported)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  write request present
in_ready  out  1  block can accept a request this cycle
s  in  3  destination select: 0=a, 1=b, 2=c, 3=d, 4=e, 5=f, 6/7 illegal
din  in  WIDTH  write data
stall  in  1  destination bank busy; no register update this cycle
err_clr  in  1  clears sticky error flag
a,b,c,d,e,f  out  WIDTH each  destination holding registers
ld  out  6  one-cycle strobe; ld[i] high the cycle after register i was updated
err  out  1  sticky: an illegal select was drained
wr_cnt  out  16  count of successful register writes

Behaviour:
- Reset (async, rst=1): a..f=0, ld=0, err=0, wr_cnt=0, FIFO count=0, in_ready=0 while rst is high.
- in_ready = !rst && (count < 2). This is combinational from count only; a pop in the same cycle does not free a slot for a push.
- Push: on a clk edge with in_valid && in_ready, {s,din} enters the FIFO tail.
- Pop: on a clk edge with !stall && count>0, the head is removed.
  - s in 0..5: the selected register takes the head data, the matching ld bit is 1 for the following cycle, and wr_cnt increments.
  - s in 6..7: the data is discarded, err sets, ld stays 0, and wr_cnt is unchanged.
- Push and pop on the same edge: both take effect and count is unchanged. Push into an empty FIFO cannot pop on that same edge.
- Latency: a request accepted at edge N updates its register at edge N+1 at the earliest, with stall low. ld is high during cycle N+1..N+2.
- ld defaults to 0 every cycle with no legal pop. At most one ld bit is high in any cycle.
- stall=1: no pop. Registers, ld (forced 0) and wr_cnt hold. Pushes continue until count=2.
- Ordering is strict FIFO. Two writes to the same register both land, and the later one wins.
- err: set by an illegal pop, cleared by err_clr. If both occur on the same edge, the set wins.
- wr_cnt wraps from 0xFFFF to 0x0000.
- Mid-operation reset: FIFO contents are dropped with no partial write, and all outputs take their reset values immediately.
- Unselected registers never change.

Decomposition:
- Shared package/header holds the select encodings SEL_A..SEL_F (0..5) and the constant NUM_DEST=6.
- One natural sub-module: fifo_2entry (WIDTH+3 bits wide, push/pop/count/full/empty). The top level holds the decode, the register bank, err and wr_cnt.

Test Plan:
1. Reset, then send s=0..5 with din=8,16,32,64,128,256, one per cycle, stall=0 -> a=8,b=16,c=32,d=64,e=128,f=256. ld runs 000001,000010,...,100000 on consecutive cycles. wr_cnt=6, err=0.
2. With stall=1, push s=2 din=0x1111, s=3 din=0x2222, s=4 din=0x3333 -> the first two are accepted and in_ready=0 at the third. After stall is released: c=0x1111, then d=0x2222, then the third request is accepted and e=0x3333.
3. Push s=6 din=0xDEAD, then s=7 -> err=1, no register changes, ld=0, wr_cnt unchanged. Assert err_clr -> err=0. err_clr on the same edge as an illegal pop -> err stays 1.
4. Push s=1 din=0x00AA, then s=1 din=0x00BB on consecutive cycles -> b=0x00AA then b=0x00BB, two ld[1] pulses, wr_cnt+=2.
5. Assert rst for one cycle while FIFO count=2 and stall=1 -> all outputs 0, in_ready returns to 1 after release, and no pre-reset entry is ever written.
6. Preload wr_cnt to 0xFFFE with 2 writes pending, then drain -> wr_cnt goes 0xFFFF, then 0x0000.
